// File: rtl/lut_mram.sv
// Configurable LUT cell: bit storage loaded serially in CONFIG_WIDTH chunks,
// usable afterwards as a read-only LUT, a 1-bit-write RAM or a shift register.
module lut_mram #(
   parameter int INPUTS       = 4,
   parameter int MEM_SIZE     = 2**INPUTS,
   parameter int CONFIG_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [INPUTS-1:0]       addr,
   input  logic [INPUTS-1:0]       waddr,
   input  logic                    data_in,
   input  logic                    write_en,
   input  logic [1:0]              mode,
   input  logic                    cen,
   input  logic [CONFIG_WIDTH-1:0] config_in,
   output logic                    out,
   output logic                    srl_out,
   output logic                    busy,
   output logic                    config_done
);

   localparam int NCH  = MEM_SIZE / CONFIG_WIDTH;
   localparam int CNTW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CNTW-1:0] LAST = CNTW'(NCH - 1);

   if (MEM_SIZE % CONFIG_WIDTH != 0) begin : g_bad_cfg
      $error("MEM_SIZE must be a multiple of CONFIG_WIDTH");
   end

   typedef enum logic {IDLE, LOAD} state_t;

   state_t                      state_q, state_d;
   logic [CNTW-1:0]             cnt_q, cnt_d;
   logic [MEM_SIZE-1:0]         mem_q, mem_d;
   logic                        done_q, done_d;
   logic [MEM_SIZE+CONFIG_WIDTH-1:0] cfg_shift;
   logic [MEM_SIZE:0]                srl_shift;

   // Concatenate-then-truncate keeps the shifts legal even when the
   // storage is a single chunk or a single bit wide.
   assign cfg_shift = {mem_q, config_in};
   assign srl_shift = {mem_q, data_in};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mem_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mem_q   <= mem_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mem_d   = mem_q;
      done_d  = 1'b0;
      if (cen) begin
         mem_d = cfg_shift[MEM_SIZE-1:0];
         if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
         end else begin
            cnt_d   = cnt_q + CNTW'(1);
            state_d = LOAD;
         end
      end else if (state_q == IDLE && write_en) begin
         // User writes only land when no configuration is in flight.
         case (mode)
            2'b01:   mem_d[waddr] = data_in;
            2'b10:   mem_d = srl_shift[MEM_SIZE-1:0];
            default: ;
         endcase
      end
   end

   assign out         = mem_q[addr];
   assign srl_out     = mem_q[MEM_SIZE-1];
   assign busy        = (state_q == LOAD);
   assign config_done = done_q;

endmodule

// File: tb/tb_lut_mram.sv
// Directed bench for lut_mram: table of configuration-load vectors plus
// hand-written RAM, SRL, reset-abort and write-during-load sequences.
module tb_lut_mram;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] addr, waddr;
   logic       data_in, write_en, cen;
   logic [1:0] mode;
   logic [3:0] config_in;
   logic       out, srl_out, busy, config_done;

   int checks   = 0;
   int failures = 0;

   lut_mram #(.INPUTS(4), .MEM_SIZE(16), .CONFIG_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .addr(addr), .waddr(waddr), .data_in(data_in),
      .write_en(write_en), .mode(mode), .cen(cen), .config_in(config_in),
      .out(out), .srl_out(srl_out), .busy(busy), .config_done(config_done)
   );

   always #20 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       cen;
      logic [3:0] cfg;
      logic [3:0] addr;
      logic       exp_busy;
      logic       exp_done;
      logic       exp_out;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reconstruct storage by sweeping the read address (fits in one period).
   task automatic read_mem(output logic [15:0] v);
      logic [3:0] save;
      save = addr;
      for (int k = 0; k < 16; k++) begin
         addr = 4'(k);
         #1;
         v[k] = out;
      end
      addr = save;
      #1;
   endtask

   task automatic chk_mem(input string name, input logic [15:0] exp);
      logic [15:0] v;
      read_mem(v);
      chk(name, 32'(v), 32'(exp));
   endtask

   task automatic do_reset();
      rst = 1'b1; cen = 1'b0; write_en = 1'b0; mode = 2'b00;
      step();
      rst = 1'b0;
   endtask

   task automatic chunk(input logic [3:0] c);
      cen = 1'b1; config_in = c;
      step();
      cen = 1'b0;
   endtask

   initial begin
      logic [15:0] v;
      int          ndone;

      rst = 1'b1; addr = '0; waddr = '0; data_in = 1'b0; write_en = 1'b0;
      cen = 1'b0; mode = 2'b00; config_in = '0;

      // rst, cen, cfg, addr, busy, done, out (sampled after the edge)
      tbl[0]  = '{1'b1, 1'b0, 4'h0, 4'd0,  1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 4'hA, 4'd3,  1'b1, 1'b0, 1'b1}; // 000A
      tbl[2]  = '{1'b0, 1'b1, 4'h5, 4'd7,  1'b1, 1'b0, 1'b1}; // 00A5
      tbl[3]  = '{1'b0, 1'b1, 4'hF, 4'd0,  1'b1, 1'b0, 1'b1}; // 0A5F
      tbl[4]  = '{1'b0, 1'b1, 4'h0, 4'd15, 1'b0, 1'b1, 1'b1}; // A5F0
      tbl[5]  = '{1'b0, 1'b0, 4'h0, 4'd0,  1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 4'hA, 4'd1,  1'b1, 1'b0, 1'b1}; // 5F0A
      tbl[7]  = '{1'b0, 1'b0, 4'h0, 4'd15, 1'b1, 1'b0, 1'b0}; // paused
      tbl[8]  = '{1'b0, 1'b0, 4'h0, 4'd14, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 4'h0, 4'd4,  1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 4'h5, 4'd15, 1'b1, 1'b0, 1'b1}; // F0A5
      tbl[11] = '{1'b0, 1'b1, 4'hF, 4'd15, 1'b1, 1'b0, 1'b0}; // 0A5F
      tbl[12] = '{1'b0, 1'b1, 4'h0, 4'd15, 1'b0, 1'b1, 1'b1}; // A5F0
      tbl[13] = '{1'b0, 1'b0, 4'h0, 4'd15, 1'b0, 1'b0, 1'b1};

      for (int i = 0; i < 14; i++) begin
         rst = tbl[i].rst; cen = tbl[i].cen; config_in = tbl[i].cfg; addr = tbl[i].addr;
         step();
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
         chk($sformatf("vec%0d_done", i), 32'(config_done), 32'(tbl[i].exp_done));
         chk($sformatf("vec%0d_out", i), 32'(out), 32'(tbl[i].exp_out));
         if (i == 4) chk_mem("load_mem", 16'hA5F0);
      end
      cen = 1'b0;
      chk_mem("gap_load_mem", 16'hA5F0);
      chk("srl_out_cfg", 32'(srl_out), 32'd1);

      // Reset state
      do_reset();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_srl_out", 32'(srl_out), 32'd0);
      chk_mem("rst_mem", 16'h0000);

      // RAM write: old value before the edge, new after
      mode = 2'b01; waddr = 4'd3; data_in = 1'b1; write_en = 1'b1; addr = 4'd3;
      #1;
      chk("ram_before_edge", 32'(out), 32'd0);
      step();
      write_en = 1'b0;
      chk("ram_after_edge", 32'(out), 32'd1);
      chk_mem("ram_other_bits", 16'h0008);

      // LUT mode (00 and 11) ignores write_en
      for (int m = 0; m < 4; m += 3) begin
         do_reset();
         mode = 2'(m); waddr = 4'd3; data_in = 1'b1; write_en = 1'b1; addr = 4'd3;
         step();
         write_en = 1'b0;
         chk($sformatf("lut_mode%0d_no_write", m), 32'(out), 32'd0);
      end

      // SRL: shift a single 1 through 16 positions
      do_reset();
      mode = 2'b10; write_en = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         data_in = (e == 1);
         step();
         read_mem(v);
         chk($sformatf("srl_mem_e%0d", e), 32'(v), 32'(16'h1 << (e - 1)));
         chk($sformatf("srl_out_e%0d", e), 32'(srl_out), 32'(e == 16));
      end
      write_en = 1'b0;

      // Mode change keeps contents: bit 15 still set when read as a LUT
      mode = 2'b00; addr = 4'd15;
      step();
      chk("mode_change_keep", 32'(out), 32'd1);

      // Reset mid-load abandons it; the next load starts fresh
      do_reset();
      chunk(4'hA);
      chunk(4'h5);
      chk("abort_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1; cen = 1'b1; config_in = 4'hF;
      step();
      rst = 1'b0; cen = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(config_done), 32'd0);
      chk_mem("abort_mem", 16'h0000);
      ndone = 0;
      chunk(4'hA); ndone += int'(config_done);
      chunk(4'h5); ndone += int'(config_done);
      chunk(4'hF); ndone += int'(config_done);
      chk("reload_busy_mid", 32'(busy), 32'd1);
      chunk(4'h0);
      chk("reload_done", 32'(config_done), 32'd1);
      chk("reload_busy", 32'(busy), 32'd0);
      step();
      ndone += int'(config_done);
      chk("reload_done_pulse_count", 32'(ndone), 32'd0);
      chk_mem("reload_mem", 16'hA5F0);

      // RAM writes during a load are dropped, on cen cycles and gap cycles
      do_reset();
      mode = 2'b01; waddr = 4'd0; data_in = 1'b1; write_en = 1'b1; addr = 4'd0;
      chunk(4'h0);
      step(); step();
      chk("busy_write_busy", 32'(busy), 32'd1);
      chunk(4'h0);
      chunk(4'h0);
      chunk(4'h0);
      write_en = 1'b0;
      chk("busy_write_done", 32'(config_done), 32'd1);
      chk_mem("busy_write_dropped", 16'h0000);
      write_en = 1'b1;
      step();
      write_en = 1'b0;
      chk("idle_write_lands", 32'(out), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lut_mram.md
LUT_MRAM -- requirements
Module: lut_mram

Interface
REQ-001 SHALL have parameter INPUTS, default 4: address width.
REQ-002 SHALL have parameter MEM_SIZE, default 2**INPUTS: storage bits.
REQ-003 SHALL have parameter CONFIG_WIDTH, default 4: configuration chunk width; MEM_SIZE SHALL be a multiple of CONFIG_WIDTH.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port addr, input, INPUTS: read address / SRL tap select.
REQ-007 SHALL have port waddr, input, INPUTS: RAM-mode write address.
REQ-008 SHALL have port data_in, input, 1: user write / shift-in bit.
REQ-009 SHALL have port write_en, input, 1: user write / shift strobe.
REQ-010 SHALL have port mode, input, 2: 00 LUT, 01 RAM, 10 SRL, 11 treated as LUT.
REQ-011 SHALL have port cen, input, 1: configuration chunk valid.
REQ-012 SHALL have port config_in, input, CONFIG_WIDTH: configuration chunk.
REQ-013 SHALL have port out, output, 1: mem[addr], combinational from stored state.
REQ-014 SHALL have port srl_out, output, 1: mem[MEM_SIZE-1], cascade output.
REQ-015 SHALL have port busy, output, 1: a configuration load is partially complete.
REQ-016 SHALL have port config_done, output, 1: registered one-cycle pulse when a load completes.

Function
REQ-017 SHALL hold storage mem[MEM_SIZE-1:0] and a chunk counter cnt of width clog2(MEM_SIZE/CONFIG_WIDTH), at least 1 bit.
REQ-018 SHALL implement FSM states IDLE (cnt=0) and LOAD (cnt>0); busy=1 exactly in LOAD.
REQ-019 SHALL, on each edge with cen=1, set mem <= {mem[MEM_SIZE-CONFIG_WIDTH-1:0], config_in}, so the first chunk ends in the top bits, and increment cnt.
REQ-020 SHALL, when the accepted chunk is number MEM_SIZE/CONFIG_WIDTH, wrap cnt to 0, go to IDLE, and assert config_done on the following cycle only.
REQ-021 SHALL, when cen=0 in LOAD, hold mem and cnt; the load pauses indefinitely with no timeout.
REQ-022 SHALL ignore write_en in every mode on any cycle where cen=1 or busy=1; configuration has priority.
REQ-023 SHALL, in LUT mode, ignore write_en; mem changes only via configuration.
REQ-024 SHALL, in RAM mode with write_en=1, set mem[waddr] <= data_in; other bits hold.
REQ-025 SHALL, in SRL mode with write_en=1, set mem <= {mem[MEM_SIZE-2:0], data_in}.
REQ-026 SHALL update out and srl_out only via state change; read-during-write to the same address shows the old value until the edge and the new value after it, with no read latency.
REQ-027 SHALL treat a change of mode as taking effect on the same edge, with mem preserved across mode changes.

Reset
REQ-028 SHALL, on rst=1 at an edge, clear mem to 0, cnt to 0, state to IDLE, and config_done to 0; hence out=0, srl_out=0, busy=0 on the next cycle.
REQ-029 SHALL give rst priority over cen and write_en; rst mid-load abandons the load with no config_done, and the next chunk starts a fresh load.

Verification
REQ-030 SHALL test: INPUTS=4, CONFIG_WIDTH=4, chunks 0xA,0x5,0xF,0x0 on 4 consecutive cycles -> mem=0xA5F0; busy=1 after chunks 1-3; config_done=1 for exactly one cycle after chunk 4; addr=15 gives out=1; addr=0 gives out=0.
REQ-031 SHALL test: chunks 0xA, then cen=0 for 3 cycles, then 0x5,0xF,0x0 -> mem=0xA5F0, busy held high during the gap, and a single config_done.
REQ-032 SHALL test: RAM mode, mem=0, waddr=3, data_in=1, write_en=1, addr=3 -> out=0 before the edge and 1 after; in LUT mode the same stimulus leaves out=0.
REQ-033 SHALL test: SRL mode, mem=0, shift 1 then fifteen 0s -> srl_out=1 after the 16th edge; during shifting, addr=k gives out=1 exactly k edges after the 1 was shifted in.
REQ-034 SHALL test: rst after chunk 2 of a load -> busy=0, mem=0, no config_done; a full 4-chunk load afterwards completes normally.
REQ-035 SHALL test: busy=1 and RAM-mode write_en=1 at waddr=0 -> write is dropped and mem[0] is unchanged after load completion except via configuration data.
